instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 80 ++++++++
 tb/tb_instr_fetch.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction fetch with a 2-deep {data, pc} buffer.
// Redirects (jump_valid/jump_addr) are honoured only when INSTR_FETCH_JUMP_EN is defined.
module instr_fetch #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              CLK_50,
    input  logic              RST,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              halt,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc
);
    logic [ADDR_W-1:0] pc, issue_pc, pc0, pc1, jmp_addr;
    logic [DATA_W-1:0] d0, d1;
    logic [1:0]        cnt;
    logic              inflight, kill, jmp, pop, push, push_head;

`ifdef INSTR_FETCH_JUMP_EN
    assign jmp      = jump_valid;
    assign jmp_addr = jump_addr;
`else
    logic unused_jump;
    assign jmp         = 1'b0;
    assign jmp_addr    = '0;
    assign unused_jump = ^{jump_valid, jump_addr};
`endif

    assign pop         = instr_valid & instr_ready;
    assign push        = inflight & ~kill & ~jmp;
    assign push_head   = (cnt == 2'd0) | ((cnt == 2'd1) & pop);
    // A slot freed by this cycle's transfer counts as free, keeping one word per cycle
    assign mem_rd      = ~RST & ~halt & ~jmp &
                         (({1'b0, cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
    assign mem_addr    = pc;
    assign instr_valid = cnt != 2'd0;
    assign instr_data  = d0;
    assign instr_pc    = pc0;

    always_ff @(posedge CLK_50) begin
        if (RST) begin
            pc       <= '0;
            issue_pc <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
            cnt      <= 2'd0;
            d0       <= '0;
            d1       <= '0;
            pc0      <= '0;
            pc1      <= '0;
        end else begin
            pc       <= jmp ? jmp_addr : (mem_rd ? pc + ADDR_W'(1) : pc);
            inflight <= mem_rd;
            // The word returning on a redirect edge is dropped by the flush; kill covers any read outstanding past it
            kill     <= inflight ? 1'b0 : (kill | (jmp & mem_rd));
            if (mem_rd)
                issue_pc <= pc;
            cnt      <= jmp ? 2'd0 : 2'(cnt + {1'b0, push} - {1'b0, pop});
            if (!jmp) begin
                if (pop) begin
                    d0  <= d1;
                    pc0 <= pc1;
                end
                if (push && push_head) begin
                    d0  <= mem_data;
                    pc0 <= issue_pc;
                end else if (push) begin
                    d1  <= mem_data;
                    pc1 <= issue_pc;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch against a synchronous ROM returning {4'hA, addr}.
module tb_instr_fetch;
    logic       CLK_50 = 1'b0;
    logic       RST = 1'b1;
    logic       mem_rd;
    logic [3:0] mem_addr;
    logic [7:0] mem_data = 8'h00;
    logic       jump_valid = 1'b0;
    logic [3:0] jump_addr = 4'h0;
    logic       halt = 1'b0;
    logic       instr_valid;
    logic       instr_ready = 1'b1;
    logic [7:0] instr_data;
    logic [3:0] instr_pc;

    int checks = 0;
    int errors = 0;
    int pops = 0;
    logic [11:0] exp_q[$];

    instr_fetch #(.DATA_W(8), .ADDR_W(4)) dut (
        .CLK_50(CLK_50), .RST(RST), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_data(mem_data), .jump_valid(jump_valid), .jump_addr(jump_addr),
        .halt(halt), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc)
    );

    always #5 CLK_50 = ~CLK_50;

    always @(posedge CLK_50)
        if (mem_rd) mem_data <= {4'hA, mem_addr};

    // Monitor: every accepted word must match the oldest expected entry
    always @(negedge CLK_50) begin
        if (instr_valid && instr_ready) begin
            checks++;
            pops++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got data=%h pc=%0d with nothing expected", instr_data, instr_pc);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if ({instr_data, instr_pc} !== e) begin
                    errors++;
                    $display("FAIL word_%0d: got data=%h pc=%0d expected data=%h pc=%0d",
                             pops, instr_data, instr_pc, e[11:4], e[3:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic expect_pcs(input logic [3:0] first, input int n);
        logic [3:0] p;
        p = first;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({4'hA, p, p});
            p = p + 4'd1;
        end
    endtask

    task automatic wait_pops(input int target, input bit gap);
        int budget;
        budget = 300;
        while (pops < target && budget > 0) begin
            if (gap) chk("no_gap", 32'(instr_valid), 32'd1);
            @(posedge CLK_50); #1;
            budget--;
        end
        if (pops < target) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d words expected %0d", pops, target);
        end
    endtask

    task automatic run_until(input int target, input bit gap);
        instr_ready = 1'b1;
        wait_pops(target, gap);
        instr_ready = 1'b0;
    endtask

    initial begin
        int p0;
        // Reset state
        repeat (3) @(posedge CLK_50);
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_data", 32'(instr_data), 32'd0);
        chk("rst_pc", 32'(instr_pc), 32'd0);
        // Stream from address 0 with wrap 15 -> 0
        expect_pcs(4'd0, 16);
        expect_pcs(4'd0, 1);
        RST = 1'b0;
        @(posedge CLK_50); #1;
        chk("latency_e0", 32'(instr_valid), 32'd0);
        @(posedge CLK_50); #1;
        chk("latency_e1", 32'(instr_valid), 32'd1);
        run_until(17, 1'b1);
        // Backpressure: head held, reads stop once buffer plus in-flight are full
        repeat (5) @(posedge CLK_50);
        #1;
        chk("stall_valid", 32'(instr_valid), 32'd1);
        chk("stall_data", 32'(instr_data), 32'hA1);
        chk("stall_pc", 32'(instr_pc), 32'd1);
        chk("stall_mem_rd", 32'(mem_rd), 32'd0);
        expect_pcs(4'd1, 3);
        run_until(20, 1'b0);
        // Halt for 4 cycles mid-stream
        expect_pcs(4'd4, 8);
        instr_ready = 1'b1;
        wait_pops(22, 1'b0);
        halt = 1'b1;
        p0 = pops;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("halt_mem_rd", 32'(mem_rd), 32'd0);
            @(posedge CLK_50); #1;
        end
        chk("halt_at_most_2", 32'(pops - p0 <= 2), 32'd1);
        halt = 1'b0;
        wait_pops(28, 1'b0);
        instr_ready = 1'b0;
        // Reset mid-stream, then redirect while address 3 is in flight
        @(posedge CLK_50); #1;
        RST = 1'b1;
        @(posedge CLK_50); #1;
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_mem_rd", 32'(mem_rd), 32'd0);
        expect_pcs(4'd0, 3);
`ifdef INSTR_FETCH_JUMP_EN
        expect_pcs(4'd9, 3);
`else
        expect_pcs(4'd3, 3);
`endif
        RST = 1'b0;
        instr_ready = 1'b1;
        repeat (4) @(posedge CLK_50);
        #1;
        jump_valid = 1'b1;
        jump_addr = 4'd9;
        #1;
`ifdef INSTR_FETCH_JUMP_EN
        chk("jump_mem_rd", 32'(mem_rd), 32'd0);
`else
        chk("jump_mem_rd", 32'(mem_rd), 32'd1);
`endif
        @(posedge CLK_50); #1;
        jump_valid = 1'b0;
        wait_pops(34, 1'b0);
        instr_ready = 1'b0;
        repeat (3) @(posedge CLK_50);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
